// File: rtl/fw_drop_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fw_drop_filter_pkg
// Description : Shared constants and encodings for the firewall drop filter
//               (default parameters, word classes, input FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package fw_drop_filter_pkg;

    // Default geometry of the filter.
    localparam int unsigned c_data_width_default    = 64;
    localparam int unsigned c_buf_addr_bits_default = 9;

    // Ctrl value the upstream firewall stamps on words of rejected packets.
    localparam int unsigned c_drop_ctrl_default     = 'h54;

    // Classification of an incoming word, resolved from ctrl and FSM state.
    typedef enum logic [1:0] {
        WORD_DATA = 2'd0,
        WORD_HDR  = 2'd1,
        WORD_EOP  = 2'd2
    } word_class_e;

    // Input-side packet FSM.
    typedef enum logic [1:0] {
        IN_HDR     = 2'd0,
        IN_DATA    = 2'd1,
        IN_DISCARD = 2'd2
    } in_state_e;

endpackage : fw_drop_filter_pkg
`default_nettype wire

// File: rtl/fw_drop_filter_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pkt_commit_buffer
// Description : Circular packet buffer with separate write, commit and read
//               pointers. Words become visible to the reader only once the
//               packet they belong to is committed; an uncommitted packet can
//               be rolled back in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_commit_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 9
) (
    input  logic                  clk,
    input  logic                  reset,          // asynchronous, active-low

    // write side
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [CTRL_WIDTH-1:0] wr_ctrl_i,
    input  logic                  commit_i,       // only together with wr_en_i
    input  logic                  rollback_i,

    // read side
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CTRL_WIDTH-1:0] rd_ctrl_o,

    // occupancy flags
    output logic                  full_o,         // wr_ptr - rd_ptr == depth
    output logic                  unc_full_o,     // wr_ptr - commit_ptr == depth
    output logic                  rd_avail_o      // committed words pending
);

    localparam int unsigned DEPTH  = 1 << ADDR_BITS;
    localparam int unsigned WORD_W = DATA_WIDTH + CTRL_WIDTH;
    localparam int unsigned PTR_W  = ADDR_BITS + 1;

    // Pointer arithmetic constants; the extra MSB is the wrap bit.
    localparam logic [PTR_W-1:0] PTR_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]  used_cnt;
    logic [PTR_W-1:0]  unc_cnt;

    // Next-state for the three pointers; rollback outranks any write.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (rollback_i) begin
            wr_ptr_d = commit_ptr_q;
        end else if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (commit_i && wr_en_i && !rollback_i) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; buffer contents survive reset untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage write port; ctrl kept alongside data in one word.
    always_ff @(posedge clk) begin
        if (wr_en_i && !rollback_i) begin
            mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= {wr_ctrl_i, wr_data_i};
        end
    end

    // Asynchronous read; the caller registers the word it pops.
    assign {rd_ctrl_o, rd_data_o} = mem_q[rd_ptr_q[ADDR_BITS-1:0]];

    assign used_cnt   = wr_ptr_q - rd_ptr_q;
    assign unc_cnt    = wr_ptr_q - commit_ptr_q;
    assign full_o     = (used_cnt == PTR_DEPTH);
    assign unc_full_o = (unc_cnt == PTR_DEPTH);
    // Reads are confined to the committed region, so a rollback never
    // disturbs an in-flight read.
    assign rd_avail_o = (rd_ptr_q != commit_ptr_q);

endmodule : pkt_commit_buffer
`default_nettype wire

// File: rtl/fw_drop_filter.sv
`default_nettype none
// ============================================================================
// Module      : fw_drop_filter
// Description : Store-and-forward stage behind the mini-firewall. Buffers
//               each packet whole and releases it only if no word carried the
//               drop marker and the packet fit in the buffer; otherwise the
//               packet is discarded. Counts forwarded and dropped packets.
// Revision    : 1.0 - initial release
// ============================================================================
module fw_drop_filter
    import fw_drop_filter_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = c_data_width_default,
    parameter int unsigned           CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] DROP_CTRL     = CTRL_WIDTH'(c_drop_ctrl_default),
    parameter int unsigned           BUF_ADDR_BITS = c_buf_addr_bits_default
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active-low

    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,

    output logic [31:0]           pkts_fwd,
    output logic [31:0]           pkts_drop
);

    // ------------------------------------------------------------------
    // Input classification and handshake
    // ------------------------------------------------------------------
    in_state_e             state_q;
    logic                  dropped_q;     // current packet carried a marked word
    logic                  seen_data_q;   // discard has passed the header words

    logic                  in_marked;
    logic                  in_is_data;
    logic                  in_accept;
    word_class_e           in_class;

    logic                  buf_wr_en;
    logic                  buf_commit;
    logic                  buf_rollback;
    logic                  buf_rd_en;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic [CTRL_WIDTH-1:0] buf_rd_ctrl;
    logic                  buf_full;
    logic                  buf_unc_full;
    logic                  buf_rd_avail;

    logic                  fwd_evt;
    logic                  drop_evt;

    logic [31:0]           pkts_fwd_q;
    logic [31:0]           pkts_drop_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic                  out_wr_q;

    // Resolve the class of the word on the input bus.
    always_comb begin
        in_marked  = (in_ctrl == DROP_CTRL);
        in_is_data = (in_ctrl == '0) || in_marked;
        if (in_is_data) begin
            in_class = WORD_DATA;
        end else if (state_q == IN_HDR) begin
            in_class = WORD_HDR;
        end else begin
            in_class = WORD_EOP;
        end
    end

    // An oversize packet must still be able to reach its overflow word even
    // when the buffer is full, otherwise input and output could deadlock.
    assign in_rdy    = !buf_full || (state_q == IN_DISCARD) || buf_unc_full;
    assign in_accept = in_wr && in_rdy;

    // ------------------------------------------------------------------
    // Buffer control decode
    // ------------------------------------------------------------------
    // Translate the accepted word and FSM state into buffer actions.
    always_comb begin
        buf_wr_en    = 1'b0;
        buf_commit   = 1'b0;
        buf_rollback = 1'b0;
        fwd_evt      = 1'b0;
        drop_evt     = 1'b0;
        if (in_accept) begin
            case (state_q)
                IN_HDR, IN_DATA: begin
                    if (buf_unc_full) begin
                        // Packet no longer fits: drop it and its overflow word.
                        buf_rollback = 1'b1;
                        drop_evt     = 1'b1;
                    end else if (in_class == WORD_EOP) begin
                        if (dropped_q) begin
                            buf_rollback = 1'b1;
                            drop_evt     = 1'b1;
                        end else begin
                            buf_wr_en  = 1'b1;
                            buf_commit = 1'b1;
                            fwd_evt    = 1'b1;
                        end
                    end else begin
                        buf_wr_en = 1'b1;
                    end
                end
                default: begin
                    // IN_DISCARD swallows words without touching the buffer.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input FSM
    // ------------------------------------------------------------------
    // Track packet boundaries, the drop marker and the discard phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IN_HDR;
            dropped_q   <= 1'b0;
            seen_data_q <= 1'b0;
        end else if (in_accept) begin
            case (state_q)
                IN_HDR: begin
                    if (buf_unc_full) begin
                        state_q     <= IN_DISCARD;
                        seen_data_q <= (in_class == WORD_DATA);
                        dropped_q   <= 1'b0;
                    end else if (in_class == WORD_DATA) begin
                        state_q   <= IN_DATA;
                        dropped_q <= in_marked;
                    end
                end
                IN_DATA: begin
                    if (in_class == WORD_EOP) begin
                        // Committed, marked or overflowing: packet ends here.
                        state_q   <= IN_HDR;
                        dropped_q <= 1'b0;
                    end else if (buf_unc_full) begin
                        state_q     <= IN_DISCARD;
                        seen_data_q <= 1'b1;
                        dropped_q   <= 1'b0;
                    end else begin
                        dropped_q <= dropped_q | in_marked;
                    end
                end
                IN_DISCARD: begin
                    // Non-data words before any data are still header words.
                    if (in_class == WORD_DATA) begin
                        seen_data_q <= 1'b1;
                    end else if (seen_data_q) begin
                        state_q     <= IN_HDR;
                        seen_data_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IN_HDR;
                end
            endcase
        end
    end

    // Forwarded / dropped packet counters, free-running and wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkts_fwd_q  <= '0;
            pkts_drop_q <= '0;
        end else begin
            if (fwd_evt) begin
                pkts_fwd_q <= pkts_fwd_q + 32'd1;
            end
            if (drop_evt) begin
                pkts_drop_q <= pkts_drop_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet buffer
    // ------------------------------------------------------------------
    pkt_commit_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH),
        .ADDR_BITS  (BUF_ADDR_BITS)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (buf_wr_en),
        .wr_data_i  (in_data),
        .wr_ctrl_i  (in_ctrl),
        .commit_i   (buf_commit),
        .rollback_i (buf_rollback),
        .rd_en_i    (buf_rd_en),
        .rd_data_o  (buf_rd_data),
        .rd_ctrl_o  (buf_rd_ctrl),
        .full_o     (buf_full),
        .unc_full_o (buf_unc_full),
        .rd_avail_o (buf_rd_avail)
    );

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    // Pop only when downstream is ready, so out_wr never follows out_rdy low.
    assign buf_rd_en = buf_rd_avail && out_rdy;

    // Register the popped word; data/ctrl hold their value between words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
        end else begin
            out_wr_q <= buf_rd_en;
            if (buf_rd_en) begin
                out_data_q <= buf_rd_data;
                out_ctrl_q <= buf_rd_ctrl;
            end
        end
    end

    assign out_wr    = out_wr_q;
    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign pkts_fwd  = pkts_fwd_q;
    assign pkts_drop = pkts_drop_q;

endmodule : fw_drop_filter
`default_nettype wire

// File: tb/tb_fw_drop_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fw_drop_filter
// Description : Directed self-checking bench for fw_drop_filter with a
//               16-word buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fw_drop_filter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AB = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr   = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b1;
    logic [31:0]   pkts_fwd;
    logic [31:0]   pkts_drop;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [71:0]   cap_q[$];
    int            cap_cyc[$];
    int            viol = 0;
    logic          prev_rdy = 1'b1;
    bit            bp_mode = 1'b0;
    logic          rdy_level = 1'b1;
    int            stall_cycles = 0;
    int            accepted = 0;
    int            last_acc_cyc = 0;

    fw_drop_filter #(
        .DATA_WIDTH    (DW),
        .CTRL_WIDTH    (CW),
        .DROP_CTRL     (8'h54),
        .BUF_ADDR_BITS (AB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .pkts_fwd  (pkts_fwd),
        .pkts_drop (pkts_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // out_rdy: either a level or a 1/0 toggle every cycle
    always @(posedge clk) begin
        #1;
        if (bp_mode) out_rdy = ~out_rdy;
        else         out_rdy = rdy_level;
    end

    // output capture
    always @(negedge clk) begin
        if (reset && out_wr) begin
            cap_q.push_back({out_ctrl, out_data});
            cap_cyc.push_back(cyc);
            if (!prev_rdy) viol++;
        end
        prev_rdy = out_rdy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim_time_exceeded");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] clean_word(input int pid, input int i, input int n);
        logic [7:0]  c;
        logic [63:0] d;
        if (i == 0)          c = 8'hFF;
        else if (i == n - 1) c = 8'h01;
        else                 c = 8'h00;
        d = 64'hC0DE_0000_0000_0000 | (64'(pid) << 16) | 64'(i);
        return {c, d};
    endfunction

    // Present one word from posedge+1 until it is accepted.
    task automatic send_word(input logic [7:0] c, input logic [63:0] d);
        int n;
        n = 0;
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
        @(negedge clk);
        while (!in_rdy && n < 300) begin
            n++;
            stall_cycles++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_rdy=%0b required=1", in_rdy);
        end else begin
            accepted++;
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        in_wr = 1'b0;
    endtask

    task automatic send_clean(input int pid, input int n);
        logic [71:0] w;
        for (int i = 0; i < n; i++) begin
            w = clean_word(pid, i, n);
            send_word(w[71:64], w[63:0]);
        end
    endtask

    task automatic wait_words(input int base, input int n, input int budget);
        int k;
        k = 0;
        while ((cap_q.size() - base) < n && k < budget) begin
            k++;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (out_wr !== 1'b0)     begin errors++; $display("FAIL reset_out_wr got=%0b exp=0", out_wr); end
        checks++; if (out_data !== 64'd0)  begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_ctrl !== 8'd0)   begin errors++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
        checks++; if (pkts_fwd !== 32'd0)  begin errors++; $display("FAIL reset_pkts_fwd got=%0d exp=0", pkts_fwd); end
        checks++; if (pkts_drop !== 32'd0) begin errors++; $display("FAIL reset_pkts_drop got=%0d exp=0", pkts_drop); end
        checks++; if (in_rdy !== 1'b1)     begin errors++; $display("FAIL reset_in_rdy got=%0b exp=1", in_rdy); end
    endtask

    task automatic test_clean;
        int base;
        int eop_cyc;
        rdy_level = 1'b1;
        do_reset();
        base = cap_q.size();
        send_clean(1, 7);
        eop_cyc = last_acc_cyc;
        wait_words(base, 7, 60);
        checks++;
        if (cap_q.size() - base != 7) begin errors++; $display("FAIL clean_count got=%0d exp=7", cap_q.size() - base); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (base + k >= cap_q.size()) begin
                errors++; $display("FAIL clean_word%0d got=missing exp=%h", k, clean_word(1, k, 7));
            end else if (cap_q[base + k] !== clean_word(1, k, 7)) begin
                errors++; $display("FAIL clean_word%0d got=%h exp=%h", k, cap_q[base + k], clean_word(1, k, 7));
            end
        end
        checks++;
        if (cap_cyc.size() <= base || cap_cyc[base] != eop_cyc + 2) begin
            errors++; $display("FAIL clean_latency got=%0d exp=%0d", (cap_cyc.size() > base) ? cap_cyc[base] - eop_cyc : -1, 2);
        end
        checks++; if (pkts_fwd !== 32'd1)  begin errors++; $display("FAIL clean_pkts_fwd got=%0d exp=1", pkts_fwd); end
        checks++; if (pkts_drop !== 32'd0) begin errors++; $display("FAIL clean_pkts_drop got=%0d exp=0", pkts_drop); end
    endtask

    task automatic test_marked;
        int base;
        logic [7:0] c;
        rdy_level = 1'b1;
        do_reset();
        base = cap_q.size();
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      c = 8'hFF;
            else if (i <= 4) c = 8'h00;
            else if (i <= 7) c = 8'h54;
            else             c = 8'h08;
            send_word(c, 64'hBAD0_0000_0000_0000 | 64'(i));
        end
        wait_words(base, 1, 12);
        checks++; if (cap_q.size() - base != 0) begin errors++; $display("FAIL marked_no_output got=%0d exp=0", cap_q.size() - base); end
        checks++; if (pkts_drop !== 32'd1) begin errors++; $display("FAIL marked_pkts_drop got=%0d exp=1", pkts_drop); end
        checks++; if (pkts_fwd !== 32'd0)  begin errors++; $display("FAIL marked_pkts_fwd got=%0d exp=0", pkts_fwd); end
        send_clean(2, 4);
        wait_words(base, 4, 60);
        checks++;
        if (cap_q.size() - base != 4) begin errors++; $display("FAIL marked_next_count got=%0d exp=4", cap_q.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= cap_q.size()) begin
                errors++; $display("FAIL marked_next_word%0d got=missing exp=%h", k, clean_word(2, k, 4));
            end else if (cap_q[base + k] !== clean_word(2, k, 4)) begin
                errors++; $display("FAIL marked_next_word%0d got=%h exp=%h", k, cap_q[base + k], clean_word(2, k, 4));
            end
        end
        checks++; if (pkts_fwd !== 32'd1) begin errors++; $display("FAIL marked_next_pkts_fwd got=%0d exp=1", pkts_fwd); end
    endtask

    task automatic test_oversize;
        int base;
        rdy_level = 1'b1;
        do_reset();
        base = cap_q.size();
        stall_cycles = 0;
        send_clean(3, 20);
        wait_words(base, 1, 12);
        checks++; if (stall_cycles != 0)        begin errors++; $display("FAIL oversize_stalls got=%0d exp=0", stall_cycles); end
        checks++; if (cap_q.size() - base != 0) begin errors++; $display("FAIL oversize_no_output got=%0d exp=0", cap_q.size() - base); end
        checks++; if (pkts_drop !== 32'd1)      begin errors++; $display("FAIL oversize_pkts_drop got=%0d exp=1", pkts_drop); end
        checks++; if (pkts_fwd !== 32'd0)       begin errors++; $display("FAIL oversize_pkts_fwd got=%0d exp=0", pkts_fwd); end
        send_clean(4, 6);
        wait_words(base, 6, 60);
        checks++;
        if (cap_q.size() - base != 6) begin errors++; $display("FAIL oversize_next_count got=%0d exp=6", cap_q.size() - base); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (base + k >= cap_q.size()) begin
                errors++; $display("FAIL oversize_next_word%0d got=missing exp=%h", k, clean_word(4, k, 6));
            end else if (cap_q[base + k] !== clean_word(4, k, 6)) begin
                errors++; $display("FAIL oversize_next_word%0d got=%h exp=%h", k, cap_q[base + k], clean_word(4, k, 6));
            end
        end
        checks++; if (pkts_fwd !== 32'd1) begin errors++; $display("FAIL oversize_next_pkts_fwd got=%0d exp=1", pkts_fwd); end
    endtask

    task automatic test_back_to_back;
        int base;
        int viol_base;
        logic [71:0] exp_w;
        rdy_level = 1'b1;
        do_reset();
        base      = cap_q.size();
        viol_base = viol;
        bp_mode   = 1'b1;
        send_clean(5, 8);
        send_clean(6, 8);
        wait_words(base, 16, 200);
        bp_mode = 1'b0;
        checks++;
        if (cap_q.size() - base != 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", cap_q.size() - base); end
        for (int k = 0; k < 16; k++) begin
            exp_w = (k < 8) ? clean_word(5, k, 8) : clean_word(6, k - 8, 8);
            checks++;
            if (base + k >= cap_q.size()) begin
                errors++; $display("FAIL b2b_word%0d got=missing exp=%h", k, exp_w);
            end else if (cap_q[base + k] !== exp_w) begin
                errors++; $display("FAIL b2b_word%0d got=%h exp=%h", k, cap_q[base + k], exp_w);
            end
        end
        checks++; if (viol - viol_base != 0) begin errors++; $display("FAIL b2b_wr_after_rdy_low got=%0d exp=0", viol - viol_base); end
        checks++; if (pkts_fwd !== 32'd2)    begin errors++; $display("FAIL b2b_pkts_fwd got=%0d exp=2", pkts_fwd); end
    endtask

    task automatic test_full_buffer;
        int base;
        int acc_at_stall;
        int out_at_stall;
        int k;
        logic rdy_after_hold;
        logic [71:0] exp_w;
        rdy_level = 1'b0;
        do_reset();
        base     = cap_q.size();
        accepted = 0;
        acc_at_stall   = -1;
        out_at_stall   = -1;
        rdy_after_hold = 1'b1;
        fork
            begin
                send_clean(7, 10);
                send_clean(8, 10);
            end
            begin
                k = 0;
                @(negedge clk);
                while (!(in_wr && !in_rdy) && k < 200) begin
                    k++;
                    @(negedge clk);
                end
                acc_at_stall = accepted;
                out_at_stall = cap_q.size() - base;
                repeat (4) @(negedge clk);
                rdy_after_hold = in_rdy;
                rdy_level = 1'b1;
            end
        join
        checks++; if (acc_at_stall != 16)     begin errors++; $display("FAIL full_stall_point got=%0d exp=16", acc_at_stall); end
        checks++; if (out_at_stall != 0)      begin errors++; $display("FAIL full_no_output_while_held got=%0d exp=0", out_at_stall); end
        checks++; if (rdy_after_hold !== 1'b0) begin errors++; $display("FAIL full_in_rdy_held got=%0b exp=0", rdy_after_hold); end
        wait_words(base, 20, 200);
        checks++;
        if (cap_q.size() - base != 20) begin errors++; $display("FAIL full_count got=%0d exp=20", cap_q.size() - base); end
        for (int j = 0; j < 20; j++) begin
            exp_w = (j < 10) ? clean_word(7, j, 10) : clean_word(8, j - 10, 10);
            checks++;
            if (base + j >= cap_q.size()) begin
                errors++; $display("FAIL full_word%0d got=missing exp=%h", j, exp_w);
            end else if (cap_q[base + j] !== exp_w) begin
                errors++; $display("FAIL full_word%0d got=%h exp=%h", j, cap_q[base + j], exp_w);
            end
        end
        checks++; if (pkts_fwd !== 32'd2)  begin errors++; $display("FAIL full_pkts_fwd got=%0d exp=2", pkts_fwd); end
        checks++; if (pkts_drop !== 32'd0) begin errors++; $display("FAIL full_pkts_drop got=%0d exp=0", pkts_drop); end
    endtask

    task automatic test_reset_mid;
        int base;
        logic [71:0] w;
        rdy_level = 1'b1;
        do_reset();
        send_clean(9, 5);
        w = clean_word(10, 0, 5); send_word(w[71:64], w[63:0]);
        w = clean_word(10, 1, 5); send_word(w[71:64], w[63:0]);
        w = clean_word(10, 2, 5);
        in_ctrl = w[71:64];
        in_data = w[63:0];
        in_wr   = 1'b1;
        @(negedge clk);
        checks++; if (pkts_fwd !== 32'd1) begin errors++; $display("FAIL midrst_pre_pkts_fwd got=%0d exp=1", pkts_fwd); end
        reset = 1'b0;
        #1;
        checks++; if (out_wr !== 1'b0)     begin errors++; $display("FAIL midrst_out_wr got=%0b exp=0", out_wr); end
        checks++; if (out_data !== 64'd0)  begin errors++; $display("FAIL midrst_out_data got=%h exp=0", out_data); end
        checks++; if (out_ctrl !== 8'd0)   begin errors++; $display("FAIL midrst_out_ctrl got=%h exp=0", out_ctrl); end
        checks++; if (pkts_fwd !== 32'd0)  begin errors++; $display("FAIL midrst_pkts_fwd got=%0d exp=0", pkts_fwd); end
        checks++; if (pkts_drop !== 32'd0) begin errors++; $display("FAIL midrst_pkts_drop got=%0d exp=0", pkts_drop); end
        in_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        base = cap_q.size();
        send_clean(11, 5);
        wait_words(base, 5, 60);
        checks++;
        if (cap_q.size() - base != 5) begin errors++; $display("FAIL midrst_next_count got=%0d exp=5", cap_q.size() - base); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (base + k >= cap_q.size()) begin
                errors++; $display("FAIL midrst_next_word%0d got=missing exp=%h", k, clean_word(11, k, 5));
            end else if (cap_q[base + k] !== clean_word(11, k, 5)) begin
                errors++; $display("FAIL midrst_next_word%0d got=%h exp=%h", k, cap_q[base + k], clean_word(11, k, 5));
            end
        end
        checks++; if (pkts_fwd !== 32'd1)  begin errors++; $display("FAIL midrst_next_pkts_fwd got=%0d exp=1", pkts_fwd); end
        checks++; if (pkts_drop !== 32'd0) begin errors++; $display("FAIL midrst_next_pkts_drop got=%0d exp=0", pkts_drop); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_marked();
        test_oversize();
        test_back_to_back();
        test_full_buffer();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fw_drop_filter
`default_nettype wire
